hazard_ctrl: RTL and testbench

Parametrised hazard controller for the pipelined ARM core. It generalises the combinational forwarding and stall logic to NRD operand ports and to multi-cycle data memory latency. A registered load scoreboard and a PC-write flush state machine replace the single-cycle hazard checks. It sits beside the D/E/M/W pipeline registers, drives their stall and flush enables, and drives the E-stage operand forwarding muxes.

---
 rtl/haz_pkg.sv | 28 ++
 rtl/haz_scoreboard.sv | 67 ++++++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// =============================================================================
// Module : haz_pkg
// Brief  : Shared encodings for the hazard controller (forward selects, FSM
//          states, PC register number, scoreboard counter width).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package haz_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // All-ones; the top slices this to its address width.
  localparam logic [31:0] PC_REG = '1;

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 4.
  localparam int c_SB_CNT_W = 2;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    PCWAIT = 1'b1
  } hazState_t;

endpackage

`default_nettype wire

// File: rtl/haz_scoreboard.sv
// =============================================================================
// Module : haz_scoreboard
// Brief  : Per-register load scoreboard (busy bit plus countdown) and D-stage
//          match; reduces to a constant miss when LOAD_LAT is 1.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module haz_scoreboard
  import haz_pkg::*;
#(
  parameter int NRD      = 3,
  parameter int AW       = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setEn,
  input  logic [AW-1:0]     setAddr,
  input  logic [NRD*AW-1:0] ra_d,
  input  logic [NRD-1:0]    rv_d,
  output logic              hit
);

  localparam int c_NREG = 1 << AW;

  generate
    if (LOAD_LAT > 1) begin : g_track
      localparam logic [c_SB_CNT_W-1:0] c_RELOAD = c_SB_CNT_W'(LOAD_LAT - 1);

      logic [c_NREG-1:0]     r_busy;
      logic [c_SB_CNT_W-1:0] r_cnt [c_NREG];

      // A new load to the same register reloads the countdown.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_busy <= '0;
          for (int r = 0; r < c_NREG; r++) r_cnt[r] <= '0;
        end else begin
          for (int r = 0; r < c_NREG; r++) begin
            if (setEn && (setAddr == AW'(r))) begin
              r_busy[r] <= 1'b1;
              r_cnt[r]  <= c_RELOAD;
            end else if (r_busy[r]) begin
              r_cnt[r] <= r_cnt[r] - 1'b1;
              if (r_cnt[r] == c_SB_CNT_W'(1)) r_busy[r] <= 1'b0;
            end
          end
        end
      end

      always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NRD; i++) begin
          if (rv_d[i] && r_busy[ra_d[i*AW +: AW]]) hit = 1'b1;
        end
      end
    end else begin : g_none
      logic w_unused;
      assign w_unused = ^{clk, reset, setEn, setAddr, ra_d, rv_d};
      assign hit      = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// =============================================================================
// Module : hazard_ctrl
// Brief  : Forwarding, load-use/scoreboard stall and PC-write flush control.
//          Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int NRD      = 3,
  parameter int AW       = 4,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra_d,
  input  logic [NRD-1:0]    rv_d,
  input  logic              regwrite_d,
  input  logic              pcwrite_d,
  input  logic [NRD*AW-1:0] ra_e,
  input  logic [AW-1:0]     wa_e,
  input  logic [AW-1:0]     wa_m,
  input  logic [AW-1:0]     wa_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              load_e,
  input  logic              load_m,
  input  logic              pc_src_e,
  input  logic              pcwb_w,
  output logic [NRD*2-1:0]  fwd_sel_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  localparam logic [AW-1:0] c_PC = PC_REG[AW-1:0];

  logic [NRD-1:0] w_luMatch;
  logic           w_loadUse;
  logic           w_sbHit;
  logic           w_hazard;
  hazState_t      r_state;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0] w_raE;
      logic [AW-1:0] w_raD;
      logic [1:0]    w_sel;

      assign w_raE        = ra_e[gi*AW +: AW];
      assign w_raD        = ra_d[gi*AW +: AW];
      assign w_luMatch[gi] = rv_d[gi] && (w_raD == wa_e);

      // Load data in M is not ready yet, so it never forwards from M.
      always_comb begin
        w_sel = FWD_RF;
        if (!reset && (w_raE != c_PC)) begin
          if (regwrite_m && (wa_m == w_raE) && !load_m) w_sel = FWD_M;
          else if (regwrite_w && (wa_w == w_raE))       w_sel = FWD_W;
        end
      end

      assign fwd_sel_e[gi*2 +: 2] = w_sel;
    end
  endgenerate

  assign w_loadUse = load_e && regwrite_e && (|w_luMatch);
  assign w_hazard  = w_loadUse || w_sbHit;

  haz_scoreboard #(
    .NRD      (NRD),
    .AW       (AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .setEn   (load_e && regwrite_e),
    .setAddr (wa_e),
    .ra_d    (ra_d),
    .rv_d    (rv_d),
    .hit     (w_sbHit)
  );

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (reset || pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (r_state == PCWAIT) begin
      flush_d = 1'b1;
      stall_f = 1'b1;
      flush_e = w_hazard;
    end else begin
      stall_f = w_hazard;
      stall_d = w_hazard;
      flush_e = w_hazard;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pc_src_e) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (pcwrite_d && regwrite_d && !stall_d) r_state <= PCWAIT;
        PCWAIT:  if (pcwb_w) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] r_stallCnt;
  logic [CW-1:0] r_flushCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (stall_d && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + CW'(1);
      if ((flush_e || pc_src_e) && (r_flushCnt != '1))
        r_flushCnt <= r_flushCnt + CW'(1);
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// =============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed bench for hazard_ctrl with LOAD_LAT=1 and LOAD_LAT=3
//          instances driven from the same pipeline stimulus.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam int EXP_LL3_CNT = 3;
`else
  localparam int EXP_LL3_CNT = 0;
`endif

  logic        clk;
  logic        reset;
  logic [11:0] ra_d;
  logic [2:0]  rv_d;
  logic        regwrite_d, pcwrite_d;
  logic [11:0] ra_e;
  logic [3:0]  wa_e, wa_m, wa_w;
  logic        regwrite_e, regwrite_m, regwrite_w;
  logic        load_e, load_m, pc_src_e, pcwb_w;

  logic [5:0]  fwd1, fwd3;
  logic        stall_f1, stall_d1, flush_d1, flush_e1;
  logic        stall_f3, stall_d3, flush_d3, flush_e3;
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;

  int nVec  = 0;
  int nMiss = 0;

  hazard_ctrl #(.NRD(3), .AW(4), .LOAD_LAT(1), .CW(32)) dut1 (
    .clk(clk), .reset(reset), .ra_d(ra_d), .rv_d(rv_d),
    .regwrite_d(regwrite_d), .pcwrite_d(pcwrite_d), .ra_e(ra_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .load_m(load_m), .pc_src_e(pc_src_e), .pcwb_w(pcwb_w),
    .fwd_sel_e(fwd1), .stall_f(stall_f1), .stall_d(stall_d1),
    .flush_d(flush_d1), .flush_e(flush_e1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  hazard_ctrl #(.NRD(3), .AW(4), .LOAD_LAT(3), .CW(32)) dut3 (
    .clk(clk), .reset(reset), .ra_d(ra_d), .rv_d(rv_d),
    .regwrite_d(regwrite_d), .pcwrite_d(pcwrite_d), .ra_e(ra_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .load_m(load_m), .pc_src_e(pc_src_e), .pcwb_w(pcwb_w),
    .fwd_sel_e(fwd3), .stall_f(stall_f3), .stall_d(stall_d3),
    .flush_d(flush_d3), .flush_e(flush_e3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    ra_d = '0; rv_d = '0; regwrite_d = 0; pcwrite_d = 0; ra_e = '0;
    wa_e = '0; wa_m = '0; wa_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    load_e = 0; load_m = 0; pc_src_e = 0; pcwb_w = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    reset = 1;
    clearIn();
    cyc();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clearIn();
    regwrite_m = 1; wa_m = 4'h5; ra_e = 12'h005;
    cyc();
    @(negedge clk);
    check("rst_fwd",     fwd1, 6'b000000);
    check("rst_stall_f", stall_f1, 0);
    check("rst_stall_d", stall_d1, 0);
    check("rst_flush_d", flush_d1, 1);
    check("rst_flush_e", flush_e1, 1);
    check("rst_scnt",    stall_cnt1, 0);
    check("rst_fcnt",    flush_cnt1, 0);
    cyc();

    // Load-use with LOAD_LAT=1: one bubble then W forwarding.
    reset = 0; clearIn();
    load_e = 1; regwrite_e = 1; wa_e = 4'h2; ra_d = 12'h002; rv_d = 3'b001;
    @(negedge clk);
    check("lu1_stall_f", stall_f1, 1);
    check("lu1_stall_d", stall_d1, 1);
    check("lu1_flush_e", flush_e1, 1);
    check("lu1_flush_d", flush_d1, 0);
    cyc(); clearIn();
    load_m = 1; regwrite_m = 1; wa_m = 4'h2; ra_d = 12'h002; rv_d = 3'b001;
    @(negedge clk);
    check("lu1_release", stall_d1, 0);
    check("lu1_no_flush", flush_e1, 0);
    cyc(); clearIn();
    regwrite_w = 1; wa_w = 4'h2; ra_e = 12'h002;
    @(negedge clk);
    check("lu1_fwd", fwd1, 6'b000001);
    cyc();

    // LOAD_LAT=3: three stall cycles on the LOAD_LAT=3 instance.
    resetPulse();
    load_e = 1; regwrite_e = 1; wa_e = 4'h4; ra_d = 12'h040; rv_d = 3'b010;
    @(negedge clk);
    check("ll3_c0", stall_d3, 1);
    for (int c = 1; c <= 3; c++) begin
      cyc(); clearIn();
      ra_d = 12'h040; rv_d = 3'b010;
      @(negedge clk);
      check($sformatf("ll3_c%0d", c), stall_d3, (c < 3) ? 1 : 0);
      check($sformatf("ll1_c%0d", c), stall_d1, 0);
    end
    check("ll3_scnt", stall_cnt3, EXP_LL3_CNT);
    check("ll3_fcnt", flush_cnt3, EXP_LL3_CNT);
    cyc();

    // Forwarding priority and r15 exclusion.
    resetPulse();
    regwrite_m = 1; wa_m = 4'h1; regwrite_w = 1; wa_w = 4'h1; ra_e = 12'h171;
    @(negedge clk);
    check("fwd_mw", fwd1, 6'b100010);
    check("fwd_mw3", fwd3, 6'b100010);
    regwrite_m = 0;
    #1 check("fwd_w", fwd1, 6'b010001);
    regwrite_m = 1; load_m = 1;
    #1 check("fwd_ldm", fwd1, 6'b010001);
    load_m = 0; wa_m = 4'hF; wa_w = 4'h3; ra_e = 12'h3FF;
    #1 check("fwd_r15", fwd1, 6'b010000);
    cyc();

    // PC write in D: PCWAIT until pcwb_w.
    resetPulse();
    pcwrite_d = 1; regwrite_d = 1;
    @(negedge clk);
    check("pc_enter_fd", flush_d1, 0);
    cyc(); clearIn();
    @(negedge clk);
    check("pcw1_fd", flush_d1, 1);
    check("pcw1_sf", stall_f1, 1);
    check("pcw1_sd", stall_d1, 0);
    cyc(); clearIn();
    @(negedge clk);
    check("pcw2_fd", flush_d1, 1);
    cyc(); pcwb_w = 1;
    @(negedge clk);
    check("pcw3_fd", flush_d1, 1);
    cyc(); clearIn();
    @(negedge clk);
    check("pcw_exit_fd", flush_d1, 0);
    check("pcw_exit_sf", stall_f1, 0);

    // A stalled PC write must not enter PCWAIT.
    cyc();
    pcwrite_d = 1; regwrite_d = 1;
    load_e = 1; regwrite_e = 1; wa_e = 4'h5; ra_d = 12'h005; rv_d = 3'b001;
    @(negedge clk);
    check("pcblk_sd", stall_d1, 1);
    cyc(); clearIn();
    @(negedge clk);
    check("pcblk_fd", flush_d1, 0);

    // Taken branch leaves PCWAIT.
    cyc(); clearIn();
    pcwrite_d = 1; regwrite_d = 1;
    cyc(); clearIn(); pc_src_e = 1;
    @(negedge clk);
    check("pcsrc_pcw_sf", stall_f1, 0);
    check("pcsrc_pcw_fd", flush_d1, 1);
    cyc(); clearIn();
    @(negedge clk);
    check("pcsrc_run_fd", flush_d1, 0);
    cyc();

    // Branch during scoreboard stall; entry keeps counting.
    resetPulse();
    load_e = 1; regwrite_e = 1; wa_e = 4'h6; ra_d = 12'h600; rv_d = 3'b100;
    @(negedge clk);
    check("plu_c0", stall_d3, 1);
    cyc(); clearIn();
    ra_d = 12'h600; rv_d = 3'b100; pc_src_e = 1;
    @(negedge clk);
    check("plu_fd3", flush_d3, 1);
    check("plu_fe3", flush_e3, 1);
    check("plu_sf3", stall_f3, 0);
    cyc(); clearIn();
    ra_d = 12'h600; rv_d = 3'b100;
    @(negedge clk);
    check("plu_sb_live", stall_d3, 1);
    cyc(); clearIn();
    ra_d = 12'h600; rv_d = 3'b100;
    @(negedge clk);
    check("plu_sb_done", stall_d3, 0);

    // Branch coinciding with a direct load-use hazard.
    load_e = 1; regwrite_e = 1; wa_e = 4'h6; pc_src_e = 1;
    #1;
    check("plu1_sf", stall_f1, 0);
    check("plu1_sd", stall_d1, 0);
    check("plu1_fd", flush_d1, 1);
    check("plu1_fe", flush_e1, 1);
    cyc();

    // Reset while in PCWAIT with r3 busy.
    resetPulse();
    load_e = 1; regwrite_e = 1; wa_e = 4'h3; pcwrite_d = 1; regwrite_d = 1;
    @(negedge clk);
    check("rpw_enter_sd", stall_d3, 0);
    cyc(); clearIn(); reset = 1;
    @(negedge clk);
    check("rpw_rst_fd", flush_d3, 1);
    check("rpw_rst_sf", stall_f3, 0);
    cyc(); reset = 0; clearIn();
    ra_d = 12'h003; rv_d = 3'b001;
    @(negedge clk);
    check("rpw_fd", flush_d3, 0);
    check("rpw_fe", flush_e3, 0);
    check("rpw_sd", stall_d3, 0);
    check("rpw_scnt", stall_cnt3, 0);
    check("rpw_fcnt", flush_cnt3, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

`default_nettype wire
